// File: rtl/imem_pkg.sv
// Shared types and helpers for the pipelined instruction memory.
// Optional feature macro: IMEM_PARITY_EN (adds an even-parity bit per RAM word).
package imem_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

`ifdef IMEM_PARITY_EN
    localparam int unsigned RAM_W = 33;
`else
    localparam int unsigned RAM_W = 32;
`endif

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_e;

    typedef logic [RAM_W-1:0] ram_word_t;

    // Fault classification captured alongside each response.
    typedef struct packed {
        logic misalign;
        logic oob;
    } rsp_flags_t;

    // Even parity over one instruction word.
    function automatic logic parity(input logic [31:0] d);
        return ^d;
    endfunction

    // Build the stored RAM word (data plus parity when enabled).
    function automatic ram_word_t make_word(input logic [31:0] d);
`ifdef IMEM_PARITY_EN
        return {parity(d), d};
`else
        return d;
`endif
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Synchronous single-port RAM; the read register holds when not enabled.
module imem_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Array write port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register; only updated by an enabled read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_pipe.sv
// Pipelined instruction memory: clear-to-NOP after reset, valid/ready fetch
// port with a one-entry response register, and a streaming program loader.
// Optional feature macro: IMEM_PARITY_EN.
module imem_pipe
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic              rsp_misalign,
    output logic              rsp_oob,
    output logic              rsp_perr,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = ADDR_W - 2;

    state_e      state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic        ld_pend_q, ld_pend_d;
    logic        rsp_valid_q, rsp_valid_d;
    rsp_flags_t  flags_q, flags_d;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    ram_word_t     ram_wdata;
    ram_word_t     ram_rdata;

    logic          accept;
    logic [IW-1:0] req_idx;
    rsp_flags_t    req_flags;
    logic          rsp_fault;

    // Request decode: fault flags use the full word index, never truncated.
    assign req_idx            = req_addr[ADDR_W-1:2];
    assign req_flags.misalign = (req_addr[1:0] != 2'b00);
    assign req_flags.oob      = (32'(req_idx) >= DEPTH);

    assign req_ready = (state_q == RUN) && !ld_pend_q && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign ld_ready  = (state_q == LOAD);
    assign busy      = (state_q != RUN) || ld_pend_q;

    // Next-state, pointer, pending-load and RAM port control.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ld_pend_d   = ld_pend_q;
        rsp_valid_d = rsp_valid_q;
        flags_d     = flags_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = ptr_q;
        ram_wdata   = make_word(NOP);

        case (state_q)
            CLEAR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                ptr_d  = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    flags_d     = req_flags;
                    // Faulted requests never touch the array.
                    ram_en      = !(req_flags.misalign || req_flags.oob);
                    ram_addr    = req_idx[AW-1:0];
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                // A pending load waits for the response register to drain.
                if (ld_pend_q && !rsp_valid_q) begin
                    state_d   = LOAD;
                    ld_pend_d = 1'b0;
                    ptr_d     = '0;
                end else if (ld_start) begin
                    ld_pend_d = 1'b1;
                end
            end
            LOAD: begin
                ram_wdata = make_word(ld_data);
                if (ld_valid) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + AW'(1);
                    if (ld_last || (ptr_q == AW'(DEPTH - 1))) begin
                        state_d = RUN;
                        ptr_d   = '0;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // State, pointer and response-control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            ld_pend_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ld_pend_q   <= ld_pend_d;
            rsp_valid_q <= rsp_valid_d;
            flags_q     <= flags_d;
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .W     (RAM_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Response payload: RAM read register, replaced by NOP on a fault.
    assign rsp_fault    = flags_q.misalign || flags_q.oob;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_misalign = flags_q.misalign;
    assign rsp_oob      = flags_q.oob;
    assign rsp_inst     = rsp_fault ? NOP : ram_rdata[31:0];

`ifdef IMEM_PARITY_EN
    assign rsp_perr = !rsp_fault && (ram_rdata[RAM_W-1] != parity(ram_rdata[31:0]));
`else
    assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_imem_pipe.sv
// Randomized and directed bench for imem_pipe against a behavioural model.
module tb_imem_pipe;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 12;
    localparam logic [31:0] NOPW   = 32'h00000013;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_inst;
    logic              rsp_misalign;
    logic              rsp_oob;
    logic              rsp_perr;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              busy;

    imem_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_inst     (rsp_inst),
        .rsp_misalign (rsp_misalign),
        .rsp_oob      (rsp_oob),
        .rsp_perr     (rsp_perr),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: memory image plus a few abstract progress variables.
    logic [31:0] mem     [DEPTH];
    bit          corrupt [DEPTH];
    int          clr_left;
    bit          loading;
    bit          pend;
    int          lptr;
    bit          e_valid;
    logic [31:0] e_inst;
    bit          e_mis;
    bit          e_oob;
    bit          e_perr;

    logic [33:0] got [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        clr_left = DEPTH;
        loading  = 0;
        pend     = 0;
        lptr     = 0;
        e_valid  = 0;
        e_inst   = '0;
        e_mis    = 0;
        e_oob    = 0;
        e_perr   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = NOPW;
            corrupt[i] = 0;
        end
    endtask

    function automatic bit m_rdy();
        return (clr_left == 0) && !loading && !pend && (!e_valid || rsp_ready);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic m_update();
        bit old_v;
        int idx;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (clr_left > 0) begin
            clr_left--;
        end else if (loading) begin
            if (ld_valid) begin
                mem[lptr]     = ld_data;
                corrupt[lptr] = 0;
                if (ld_last || lptr == DEPTH - 1) loading = 0;
                lptr++;
            end
        end else begin
            old_v = e_valid;
            if (req_valid && m_rdy()) begin
                idx     = int'(req_addr[ADDR_W-1:2]);
                e_mis   = (req_addr[1:0] != 2'b00);
                e_oob   = (idx >= DEPTH);
                e_inst  = NOPW;
                e_perr  = 0;
                if (!e_mis && !e_oob) begin
                    e_inst = mem[idx];
                    e_perr = corrupt[idx];
                end
                e_valid = 1;
            end else if (rsp_ready) begin
                e_valid = 0;
            end
            if (pend && !old_v) begin
                loading = 1;
                pend    = 0;
                lptr    = 0;
            end else if (ld_start) begin
                pend = 1;
            end
        end
    endtask

    // One clock: compare DUT against model, record accepted responses, advance.
    task automatic step();
        #1;
        if (!rst_n) m_reset();
        chk("busy", busy, (clr_left > 0) || loading || pend);
        chk("req_ready", req_ready, m_rdy());
        chk("ld_ready", ld_ready, loading);
        chk("rsp_valid", rsp_valid, e_valid);
        if (e_valid) begin
            chk("rsp_inst", rsp_inst, e_inst);
            chk("rsp_misalign", rsp_misalign, e_mis);
            chk("rsp_oob", rsp_oob, e_oob);
            chk("rsp_perr", rsp_perr, e_perr);
        end
`ifndef IMEM_PARITY_EN
        chk("perr_tied", rsp_perr, 1'b0);
`endif
        if (rsp_valid && rsp_ready) got.push_back({rsp_misalign, rsp_oob, rsp_inst});
        m_update();
        @(negedge clk);
    endtask

    task automatic chk_got(input string name, input logic [33:0] exp);
        logic [33:0] g;
        if (got.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no response captured, expected %h", name, exp);
        end else begin
            g = got.pop_front();
            chk(name, g, exp);
        end
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        bit done;
        done      = 0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 50 && !done; i++) begin
            done = m_rdy();
            step();
        end
        if (!done) chk("fetch_timeout", 1'b0, 1'b1);
    endtask

    task automatic load_words(input logic [31:0] w [$], input bit last);
        bit done;
        for (int k = 0; k < w.size(); k++) begin
            if ($urandom_range(0, 1) == 1) begin
                ld_valid = 1'b0;
                step();
            end
            ld_valid = 1'b1;
            ld_data  = w[k];
            ld_last  = last && (k == w.size() - 1);
            done     = 0;
            for (int i = 0; i < 50 && !done; i++) begin
                done = loading;
                step();
            end
            if (!done) chk("load_timeout", 1'b0, 1'b1);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [$];
        logic [31:0] junk [$];
        rst_n = 1'b1; req_valid = 0; req_addr = '0; rsp_ready = 1'b1;
        ld_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
        m_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Reset values.
        step();
        step();
        chk("rst_busy", busy, 1'b1);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_inst", rsp_inst, 32'h0);
        chk("rst_ld_ready", ld_ready, 1'b0);

        // CLEAR lasts DEPTH cycles.
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        #1;
        chk("clear_len_busy", busy, 1'b0);
        chk("clear_len_ready", req_ready, 1'b1);
        @(negedge clk);

        // Fetch from cleared memory.
        got.delete();
        fetch(12'h008);
        req_valid = 1'b0;
        step();
        chk_got("fetch_cleared", {1'b0, 1'b0, NOPW});

        // Program load then back-to-back fetches.
        prog = '{32'h00100093, 32'h00200113, 32'h00208433};
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        load_words(prog, 1'b1);
        for (int i = 0; i < 4 && loading; i++) step();
        fetch(12'h000);
        fetch(12'h004);
        fetch(12'h008);
        fetch(12'h00C);
        req_valid = 1'b0;
        step();
        chk_got("load_w0", {2'b00, 32'h00100093});
        chk_got("load_w1", {2'b00, 32'h00200113});
        chk_got("load_w2", {2'b00, 32'h00208433});
        chk_got("load_w3_nop", {2'b00, NOPW});

        // Fault flags.
        fetch(12'h006);
        fetch(12'h040);
        fetch(12'h042);
        req_valid = 1'b0;
        step();
        chk_got("misalign", {1'b1, 1'b0, NOPW});
        chk_got("oob", {1'b0, 1'b1, NOPW});
        chk_got("both", {1'b1, 1'b1, NOPW});

        // Backpressure with a load requested mid-stall.
        fetch(12'h004);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 12'h008;
        for (int i = 0; i < 5; i++) begin
            ld_start = (i == 1);
            step();
            chk("stall_inst", rsp_inst, 32'h00200113);
            chk("stall_ready", req_ready, 1'b0);
        end
        ld_start = 1'b0;
        chk("stall_no_load", ld_ready, 1'b0);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        step();
        step();
        chk("load_after_drain", ld_ready, 1'b1);
        chk_got("stall_word", {2'b00, 32'h00200113});

        // Reset in the middle of a load.
        junk = '{32'hDEADBEEF, 32'h12345678};
        load_words(junk, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_ld_ready", ld_ready, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_rsp_inst", rsp_inst, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        got.delete();
        fetch(12'h000);
        req_valid = 1'b0;
        step();
        chk_got("post_rst_nop", {2'b00, NOPW});

`ifdef IMEM_PARITY_EN
        // Corrupt the parity bit of word 1.
        dut.u_ram.mem[1][32] = ~dut.u_ram.mem[1][32];
        corrupt[1] = 1;
        fetch(12'h004);
        req_valid = 1'b0;
        #1;
        chk("perr_flag", rsp_perr, 1'b1);
        @(negedge clk);
        step();
`endif

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_addr  = ADDR_W'($urandom_range(0, 'h5F));
            rsp_ready = ($urandom_range(0, 3) != 0);
            ld_start  = !pend && ($urandom_range(0, 39) == 0);
            ld_valid  = ($urandom_range(0, 2) != 0);
            ld_data   = $urandom;
            ld_last   = ($urandom_range(0, 5) == 0);
            step();
        end
        req_valid = 0; ld_start = 0; ld_valid = 0; ld_last = 0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
